// File: rtl/outstanding_id_scheduler_if.sv
// Bus bundle for the outstanding-ID scheduler: allocation handshake, response
// retirement, drain control and status/debug outputs.
interface outstanding_id_scheduler_if #(
    parameter int ID_W = 6
);
    // Allocation handshake: alloc_req is a per-cycle request; the ID on alloc_id
    // is issued exactly on a rising clock edge where alloc_req && alloc_gnt.
    // alloc_gnt is combinational and never depends on alloc_gnt feedback.
    logic            alloc_req;
    logic            alloc_gnt;
    logic [ID_W-1:0] alloc_id;
    logic            resp_valid;
    logic [ID_W-1:0] resp_id;
    logic            drain;
    logic            drain_done;
    logic            oldest_valid;
    logic [ID_W-1:0] oldest_id;
    logic [ID_W:0]   outstanding_cnt;
    logic            full;
    logic            err_resp;
    logic            timeout;
    logic [1:0]      fsm_state;

    modport master (
        output alloc_req, resp_valid, resp_id, drain,
        input  alloc_gnt, alloc_id, drain_done, oldest_valid, oldest_id,
               outstanding_cnt, full, err_resp, timeout, fsm_state
    );

    modport slave (
        input  alloc_req, resp_valid, resp_id, drain,
        output alloc_gnt, alloc_id, drain_done, oldest_valid, oldest_id,
               outstanding_cnt, full, err_resp, timeout, fsm_state
    );
endinterface

// File: rtl/outstanding_id_scheduler.sv
// Issues sequential IDs, retires them out of order and tracks the oldest pending
// ID. Optional oldest-ID age watchdog is enabled with `define SCHED_TIMEOUT_EN.
module outstanding_id_scheduler #(
    parameter int ID_W            = 6,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic clk,
    input logic reset,
    outstanding_id_scheduler_if.slave bus
);
    localparam int DEPTH = 1 << ID_W;
    localparam logic [ID_W:0] MAX_SPAN = (ID_W+1)'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [ID_W:0]    head_q, head_d;
    logic [ID_W:0]    tail_q, tail_d;
    logic [ID_W:0]    cnt_q, cnt_d;
    logic [ID_W:0]    span, span_after;
    logic [ID_W-1:0]  scan_idx;
    logic [1:0]       state_q, state_d;
    logic             full_q, full_d;
    logic             err_q;
    logic             gnt, retire, oldest_valid;

    assign gnt          = bus.alloc_req && (state_q == ST_RUN) && !full_q;
    assign retire       = bus.resp_valid && pending_q[bus.resp_id];
    assign oldest_valid = (head_q != tail_q);
    assign span         = tail_q - head_q;

    // The granted slot is never pending (full blocks aliasing), so the set and
    // clear below always hit different bits.
    always_comb begin
        pending_d = pending_q;
        if (gnt)    pending_d[tail_q[ID_W-1:0]] = 1'b1;
        if (retire) pending_d[bus.resp_id]      = 1'b0;
    end

    assign tail_d = gnt ? tail_q + (ID_W+1)'(1) : tail_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({gnt, retire})
            2'b10:   cnt_d = cnt_q + (ID_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (ID_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Full-window scan: descending loop so the lowest offset from head wins.
    always_comb begin
        head_d   = tail_q;
        scan_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = head_q[ID_W-1:0] + ID_W'(i);
            if (((ID_W+1)'(i) < span) && pending_q[scan_idx])
                head_d = head_q + (ID_W+1)'(i);
        end
    end

    // Uses the current head, so a retire frees window space one cycle after the
    // head moves; a fresh grant is seen immediately, which prevents overrun.
    assign span_after = tail_d - head_q;
    assign full_d     = (span_after == MAX_SPAN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (bus.drain) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.drain)         state_d = ST_RUN;
                else if (cnt_q == '0)   state_d = ST_DRAINED;
            end
            ST_DRAINED: if (!bus.drain) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            pending_q <= pending_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            err_q     <= bus.resp_valid && !pending_q[bus.resp_id];
            state_q   <= state_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES - 1);

    logic [AGE_W-1:0] age_q, age_d;
    logic             timeout_q;

    always_comb begin
        age_d = age_q;
        if (!oldest_valid || (head_d != head_q)) age_d = '0;
        else if (age_q != AGE_MAX)               age_d = age_q + AGE_W'(1);
    end

    // Fires only on the transition into saturation, so one pulse per stuck head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            age_q     <= age_d;
            timeout_q <= (age_d == AGE_MAX) && (age_q != AGE_MAX);
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.alloc_gnt       = gnt;
    assign bus.alloc_id        = tail_q[ID_W-1:0];
    assign bus.oldest_valid    = oldest_valid;
    assign bus.oldest_id       = oldest_valid ? head_q[ID_W-1:0] : '0;
    assign bus.outstanding_cnt = cnt_q;
    assign bus.full            = full_q;
    assign bus.err_resp        = err_q;
    assign bus.drain_done      = (state_q == ST_DRAINED);
    assign bus.fsm_state       = state_q;
endmodule
